// File: rtl/router_pkg.sv
// Shared router constants, arbiter state type and one-hot/index helpers.
package router_pkg;

  localparam int NPORTS = 16;
  localparam int PTR_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [NPORTS-1:0] to_onehot(input logic [PTR_W-1:0] idx);
    return NPORTS'(1) << idx;
  endfunction

  // Assumes at most one bit set; zero maps to index 0.
  function automatic logic [PTR_W-1:0] to_index(input logic [NPORTS-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant/data bundle between the input-port FSMs and one output arbiter.
interface output_port_arbiter_if;
  import router_pkg::*;

  logic [NPORTS-1:0] req_in;
  logic [NPORTS-1:0] din_in;
  logic [NPORTS-1:0] data_enable_in;
  logic [NPORTS-1:0] grant_out;
  logic              busy_out;
  logic              dout_out;
  logic              valido_n_out;

  modport master (
    output req_in, din_in, data_enable_in,
    input  grant_out, busy_out, dout_out, valido_n_out
  );

  modport slave (
    input  req_in, din_in, data_enable_in,
    output grant_out, busy_out, dout_out, valido_n_out
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: rotate requests by rr_ptr, take lowest set bit, un-rotate.
module rr_priority_pick
  import router_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic              found,
  output logic [PTR_W-1:0]  winner
);

  logic [NPORTS-1:0] rot;
  logic [NPORTS-1:0] lowest;

  always_comb begin
    rot    = NPORTS'({req, req} >> rr_ptr);
    lowest = rot & (~rot + NPORTS'(1));
    found  = |req;
    winner = to_index(lowest) + rr_ptr;
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output round-robin arbiter with registered serial data mux.
//   state   | meaning
//   IDLE    | no owner, arbitrate among requests from rr_ptr
//   GRANT   | owner holds the port, its data is forwarded
//   RELEASE | one-cycle turnaround, grant low, still busy
module output_port_arbiter
  import router_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  output_port_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              dout_q, dout_d;
  logic              valid_n_q, valid_n_d;

  logic              found;
  logic [PTR_W-1:0]  winner;

  rr_priority_pick u_pick (
    .req    (bus.req_in),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    dout_d    = 1'b0;
    valid_n_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy_d  = 1'b0;
        grant_d = '0;
        if (found) begin
          owner_d = winner;
          grant_d = to_onehot(winner);
          busy_d  = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        dout_d    = bus.din_in[owner_q];
        valid_n_d = ~bus.data_enable_in[owner_q];
        if (!bus.req_in[owner_q]) begin
          grant_d  = '0;
          rr_ptr_d = owner_q + PTR_W'(1);
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      dout_q    <= 1'b0;
      valid_n_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      dout_q    <= dout_d;
      valid_n_q <= valid_n_d;
    end
  end

  assign bus.grant_out    = grant_q;
  assign bus.busy_out     = busy_q;
  assign bus.dout_out     = dout_q;
  assign bus.valido_n_out = valid_n_q;

endmodule
